game_status_display: RTL and testbench

//  Consumer of the round-status flags (gamestart, gameover, complete) produced by the end-of-game detector.

---
 rtl/game_pkg.sv | 18 +
 rtl/bcd_counter3.sv | 38 +++
 rtl/game_status_display.sv | 158 +++++++++++++++
 tb/tb_game_status_display.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Round-lifecycle state encoding and result-banner codes shared by the
// status display and anything that decodes its banner output.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    LOSE,
    WIN,
    OUT
  } round_state_t;

  localparam logic [1:0] BANNER_NONE = 2'd0;
  localparam logic [1:0] BANNER_LOSE = 2'd1;
  localparam logic [1:0] BANNER_WIN  = 2'd2;
  localparam logic [1:0] BANNER_OUT  = 2'd3;

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter, clear has priority over increment, saturates at 999.
// Registered output: value changes one cycle after clr/inc are sampled.
module bcd_counter3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] value
);

  logic [11:0] value_nxt;

  always_comb begin
    value_nxt = value;
    if (clr) begin
      value_nxt = 12'h000;
    end else if (inc && (value != 12'h999)) begin
      if (value[3:0] != 4'd9) begin
        value_nxt[3:0] = value[3:0] + 4'd1;
      end else begin
        value_nxt[3:0] = 4'd0;
        // hundreds cannot overflow here: 999 is excluded above
        if (value[7:4] != 4'd9) begin
          value_nxt[7:4] = value[7:4] + 4'd1;
        end else begin
          value_nxt[7:4]  = 4'd0;
          value_nxt[11:8] = value[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= 12'h000;
    else       value <= value_nxt;
  end

endmodule

// File: rtl/game_status_display.sv
// Round lifecycle tracker: lives, elapsed seconds, freeze, blinking result banner
// and post-loss restart request. All outputs registered, one cycle after the sampling edge.
module game_status_display
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BLINK_TICKS   = 12_500_000,
  parameter int LIVES         = 3,
  parameter int HOLD_SEC      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gamestart,
  input  logic        gameover,
  input  logic        complete,
  output logic        freeze,
  output logic [1:0]  banner,
  output logic        banner_on,
  output logic [2:0]  lives,
  output logic [11:0] time_bcd,
  output logic        restart_req
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HW = $clog2(HOLD_SEC + 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_SEC - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  round_state_t   state, state_nxt;
  logic           gamestart_q, gameover_q;
  logic           gs_rise, go_rise;
  logic [PW-1:0]  pre, pre_nxt;
  logic           pre_wrap;
  logic [HW-1:0]  hold, hold_nxt;
  logic [BW-1:0]  blink_cnt;
  logic [1:0]     banner_nxt;
  logic [2:0]     lives_nxt, lives_dec;
  logic           restart_nxt;
  logic           time_inc, time_clr;

  assign gs_rise  = gamestart & ~gamestart_q;
  assign go_rise  = gameover & ~gameover_q;
  assign pre_wrap = (pre == PRE_MAX);

  always_comb begin
    state_nxt   = state;
    banner_nxt  = banner;
    lives_nxt   = lives;
    lives_dec   = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
    pre_nxt     = pre;
    hold_nxt    = hold;
    restart_nxt = 1'b0;
    time_inc    = 1'b0;
    time_clr    = 1'b0;

    // a new round start overrides everything, including a same-cycle gameover edge
    if (gs_rise) begin
      state_nxt  = PLAY;
      banner_nxt = BANNER_NONE;
      pre_nxt    = '0;
      time_clr   = 1'b1;
      if (state == OUT) lives_nxt = LIVES_INIT;
    end else begin
      case (state)
        PLAY: begin
          pre_nxt  = pre_wrap ? '0 : pre + PW'(1);
          time_inc = pre_wrap;
          if (go_rise) begin
            if (complete) begin
              state_nxt  = WIN;
              banner_nxt = BANNER_WIN;
            end else begin
              lives_nxt = lives_dec;
              hold_nxt  = '0;
              pre_nxt   = '0;
              if (lives_dec == 3'd0) begin
                state_nxt  = OUT;
                banner_nxt = BANNER_OUT;
              end else begin
                state_nxt  = LOSE;
                banner_nxt = BANNER_LOSE;
              end
            end
          end
        end
        LOSE: begin
          pre_nxt = pre_wrap ? '0 : pre + PW'(1);
          if (pre_wrap) begin
            if (hold == HOLD_MAX) begin
              restart_nxt = 1'b1;
              state_nxt   = IDLE;
              banner_nxt  = BANNER_NONE;
              hold_nxt    = '0;
            end else begin
              hold_nxt = hold + HW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gamestart_q <= 1'b0;
      gameover_q  <= 1'b0;
      pre         <= '0;
      hold        <= '0;
      lives       <= LIVES_INIT;
      banner      <= BANNER_NONE;
      freeze      <= 1'b1;
      restart_req <= 1'b0;
    end else begin
      state       <= state_nxt;
      gamestart_q <= gamestart;
      gameover_q  <= gameover;
      pre         <= pre_nxt;
      hold        <= hold_nxt;
      lives       <= lives_nxt;
      banner      <= banner_nxt;
      freeze      <= (state_nxt != PLAY);
      restart_req <= restart_nxt;
    end
  end

  // a fresh banner always starts visible with a full blink period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      banner_on <= 1'b0;
    end else if (banner_nxt != banner) begin
      blink_cnt <= '0;
      banner_on <= (banner_nxt != BANNER_NONE);
    end else if (banner == BANNER_NONE) begin
      blink_cnt <= '0;
      banner_on <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      banner_on <= ~banner_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  bcd_counter3 u_time (
    .clk   (clk),
    .reset (reset),
    .clr   (time_clr),
    .inc   (time_inc),
    .value (time_bcd)
  );

endmodule

// File: tb/tb_game_status_display.sv
// Directed vector bench for game_status_display with small timing parameters.
module tb_game_status_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gamestart = 1'b0;
  logic        gameover = 1'b0;
  logic        complete = 1'b0;
  logic        freeze;
  logic [1:0]  banner;
  logic        banner_on;
  logic [2:0]  lives;
  logic [11:0] time_bcd;
  logic        restart_req;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  // cycles with restart_req high, counted on the falling edge
  always @(negedge clk) if (restart_req === 1'b1) pulses = pulses + 1;

  game_status_display #(
    .TICKS_PER_SEC (4),
    .BLINK_TICKS   (2),
    .LIVES         (2),
    .HOLD_SEC      (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gamestart   (gamestart),
    .gameover    (gameover),
    .complete    (complete),
    .freeze      (freeze),
    .banner      (banner),
    .banner_on   (banner_on),
    .lives       (lives),
    .time_bcd    (time_bcd),
    .restart_req (restart_req)
  );

  typedef struct {
    string       name;
    int          n;
    logic        rst, gs, go, cp;
    logic        fz;
    logic [1:0]  bn;
    logic        on;
    logic [2:0]  lv;
    logic [11:0] tm;
    logic        rr;
    int          pc;
  } vec_t;

  vec_t vecs[29];

  task automatic chk(input string name, input string field, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", name, field, act, exp);
    end
  endtask

  task automatic chk_all(input vec_t v);
    chk(v.name, "freeze", int'(freeze), int'(v.fz));
    chk(v.name, "banner", int'(banner), int'(v.bn));
    chk(v.name, "banner_on", int'(banner_on), int'(v.on));
    chk(v.name, "lives", int'(lives), int'(v.lv));
    chk(v.name, "time_bcd", int'(time_bcd), int'(v.tm));
    chk(v.name, "restart_req", int'(restart_req), int'(v.rr));
    chk(v.name, "pulses", pulses, v.pc);
  endtask

  initial begin
    //            name        n  rst gs go cp  fz bn on lv tm      rr pc
    vecs[0]  = '{"rst",       2, 1, 0, 0, 0,  1, 0, 0, 2, 12'h000, 0, 0};
    vecs[1]  = '{"idle",      3, 0, 0, 0, 0,  1, 0, 0, 2, 12'h000, 0, 0};
    vecs[2]  = '{"start",     1, 0, 1, 0, 0,  0, 0, 0, 2, 12'h000, 0, 0};
    vecs[3]  = '{"play40",   40, 0, 0, 0, 0,  0, 0, 0, 2, 12'h010, 0, 0};
    vecs[4]  = '{"play41",    1, 0, 0, 0, 0,  0, 0, 0, 2, 12'h010, 0, 0};
    vecs[5]  = '{"win",       1, 0, 0, 1, 1,  1, 2, 1, 2, 12'h010, 0, 0};
    vecs[6]  = '{"win_b1",    1, 0, 0, 1, 1,  1, 2, 1, 2, 12'h010, 0, 0};
    vecs[7]  = '{"win_b2",    1, 0, 0, 1, 1,  1, 2, 0, 2, 12'h010, 0, 0};
    vecs[8]  = '{"win_b3",    1, 0, 0, 1, 1,  1, 2, 0, 2, 12'h010, 0, 0};
    vecs[9]  = '{"win_b4",    1, 0, 0, 1, 1,  1, 2, 1, 2, 12'h010, 0, 0};
    vecs[10] = '{"restart1",  1, 0, 1, 0, 0,  0, 0, 0, 2, 12'h000, 0, 0};
    vecs[11] = '{"run5",      5, 0, 0, 0, 0,  0, 0, 0, 2, 12'h001, 0, 0};
    vecs[12] = '{"loss1",     1, 0, 0, 1, 0,  1, 1, 1, 1, 12'h001, 0, 0};
    vecs[13] = '{"hold7",     7, 0, 0, 1, 0,  1, 1, 0, 1, 12'h001, 0, 0};
    vecs[14] = '{"pulse",     1, 0, 0, 1, 0,  1, 0, 0, 1, 12'h001, 1, 0};
    vecs[15] = '{"post_pls",  1, 0, 0, 1, 0,  1, 0, 0, 1, 12'h001, 0, 1};
    vecs[16] = '{"restart2",  1, 0, 1, 0, 0,  0, 0, 0, 1, 12'h000, 0, 1};
    vecs[17] = '{"run2",      2, 0, 0, 0, 0,  0, 0, 0, 1, 12'h000, 0, 1};
    vecs[18] = '{"out",       1, 0, 0, 1, 0,  1, 3, 1, 0, 12'h000, 0, 1};
    vecs[19] = '{"out_hold", 10, 0, 0, 1, 0,  1, 3, 0, 0, 12'h000, 0, 1};
    vecs[20] = '{"newgame",   1, 0, 1, 0, 0,  0, 0, 0, 2, 12'h000, 0, 1};
    vecs[21] = '{"run1",      1, 0, 0, 0, 0,  0, 0, 0, 2, 12'h000, 0, 1};
    vecs[22] = '{"both_rise", 1, 0, 1, 1, 0,  0, 0, 0, 2, 12'h000, 0, 1};
    vecs[23] = '{"go_held",   3, 0, 0, 1, 0,  0, 0, 0, 2, 12'h000, 0, 1};
    vecs[24] = '{"go_low",    1, 0, 0, 0, 0,  0, 0, 0, 2, 12'h001, 0, 1};
    vecs[25] = '{"loss2",     1, 0, 0, 1, 0,  1, 1, 1, 1, 12'h001, 0, 1};
    vecs[26] = '{"hold3",     3, 0, 0, 1, 0,  1, 1, 0, 1, 12'h001, 0, 1};
    vecs[27] = '{"rst_hold",  1, 1, 0, 1, 0,  1, 0, 0, 2, 12'h000, 0, 1};
    vecs[28] = '{"after_rst", 8, 0, 0, 0, 0,  1, 0, 0, 2, 12'h000, 0, 1};

    for (int i = 0; i < 29; i++) begin
      reset     = vecs[i].rst;
      gamestart = vecs[i].gs;
      gameover  = vecs[i].go;
      complete  = vecs[i].cp;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      chk_all(vecs[i]);
    end

    // asynchronous reset in the middle of a clock cycle, during PLAY
    gamestart = 1'b1;
    @(posedge clk); #1;
    gamestart = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("async_pre", "time_bcd", int'(time_bcd), 12'h001);
    chk("async_pre", "freeze", int'(freeze), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", "freeze", int'(freeze), 1);
    chk("async_rst", "time_bcd", int'(time_bcd), 0);
    chk("async_rst", "lives", int'(lives), 2);
    chk("async_rst", "banner", int'(banner), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_again", "freeze", int'(freeze), 1);
    chk("idle_again", "restart_req", int'(restart_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
